fifo_reader: RTL

FIFO_READER -- requirements
Module: fifo_reader

---
 rtl/fifo_reader.sv | 100 ++++++++++
 1 files changed

// File: rtl/fifo_reader.sv
// fifo_reader: turns a latency-1 FIFO read port into a first-word-fall-through
// valid/ready stream using a 2-entry skid buffer. Sustains one word per cycle.
module fifo_reader #(
   parameter int unsigned D_SIZE   = 8,
   parameter int unsigned CNT_SIZE = 16
) (
   input  logic                CLK,
   input  logic                RST,
   output logic                R_INC,
   input  logic [D_SIZE-1:0]   R_DATA,
   input  logic                EMPTY,
   output logic                OUT_VALID,
   input  logic                OUT_READY,
   output logic [D_SIZE-1:0]   OUT_DATA,
   output logic [CNT_SIZE-1:0] WORD_CNT
);

   typedef enum logic [1:0] {StBuf0, StBuf1, StBuf2} state_e;

   state_e              state_q, state_d;
   logic [D_SIZE-1:0]   buf0_q, buf0_d;  // head (oldest word)
   logic [D_SIZE-1:0]   buf1_q, buf1_d;  // second word, valid only in StBuf2
   logic                inflight_q;      // a read issued last cycle returns now
   logic                started_q;       // blocks reads in the first cycle after reset
   logic [CNT_SIZE-1:0] cnt_q;
   logic [1:0]          occ;
   logic                pop;
   logic                fill;

   // Occupancy, handshake and read-strobe decode.
   always_comb begin
      occ = 2'd0;
      case (state_q)
         StBuf1:  occ = 2'd1;
         StBuf2:  occ = 2'd2;
         default: occ = 2'd0;
      endcase
      OUT_VALID = (state_q != StBuf0);
      OUT_DATA  = buf0_q;
      WORD_CNT  = cnt_q;
      pop       = OUT_VALID && OUT_READY;
      fill      = inflight_q;
      // occ + inflight - pop < 2, rearranged to avoid a negative intermediate.
      R_INC     = started_q && !EMPTY &&
                  (({1'b0, occ} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));
   end

   // Buffer next-state. A fill in StBuf2 cannot happen: a read is only issued
   // when the returning word is guaranteed a free slot.
   always_comb begin
      state_d = state_q;
      buf0_d  = buf0_q;
      buf1_d  = buf1_q;
      case (state_q)
         StBuf0: begin
            if (fill) begin
               buf0_d  = R_DATA;
               state_d = StBuf1;
            end
         end
         StBuf1: begin
            if (fill && pop) begin
               buf0_d = R_DATA;
            end else if (fill) begin
               buf1_d  = R_DATA;
               state_d = StBuf2;
            end else if (pop) begin
               state_d = StBuf0;
            end
         end
         StBuf2: begin
            if (pop) begin
               buf0_d  = buf1_q;
               state_d = StBuf1;
            end
         end
         default: state_d = StBuf0;
      endcase
   end

   // State, buffer and counter registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= StBuf0;
         buf0_q     <= '0;
         buf1_q     <= '0;
         inflight_q <= 1'b0;
         started_q  <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         buf0_q     <= buf0_d;
         buf1_q     <= buf1_d;
         inflight_q <= R_INC;
         started_q  <= 1'b1;
         cnt_q      <= cnt_q + {{(CNT_SIZE-1){1'b0}}, pop};
      end
   end

endmodule
